// File: rtl/vga_scan_compositor.sv
// VGA scan generator and sprite compositor: drives row/col addresses to the sprite layers,
// merges their registered pixels by priority and produces aligned hs/vs/rdn/rgb plus collision.
module vga_scan_compositor #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clkdiv,
  input  logic        RESET,
  input  logic        px_dino,
  input  logic        px_cactus,
  input  logic        px_ground,
  input  logic        clr_collision,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        fresh,
  output logic        hs,
  output logic        vs,
  output logic        rdn,
  output logic [11:0] rgb,
  output logic        collision
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] L_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] L_H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] L_H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] L_H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] L_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] L_V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] L_V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] L_V_LAST     = 10'(V_TOT - 1);

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        w_h_wrap;
  logic        w_vis;
  logic        w_hs0;
  logic        w_vs0;
  logic [11:0] w_pix;

  logic        r_vis_d1;
  logic        r_hs_d1;
  logic        r_vs_d1;
  logic        r_fresh;
  logic        r_hs;
  logic        r_vs;
  logic        r_rdn;
  logic [11:0] r_rgb;
  logic        r_collision;

  always_comb begin
    w_h_wrap = (r_h_cnt == L_H_LAST);
    w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == L_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  always_comb begin
    w_vis = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
    w_hs0 = !((r_h_cnt >= L_H_SYNC_BEG) && (r_h_cnt <= L_H_SYNC_END));
    w_vs0 = !((r_v_cnt >= L_V_SYNC_BEG) && (r_v_cnt <= L_V_SYNC_END));
  end

  // Layer priority: dino over cactus over ground over background.
  always_comb begin
    if (px_dino) begin
      w_pix = 12'h555;
    end else if (px_cactus) begin
      w_pix = 12'h070;
    end else if (px_ground) begin
      w_pix = 12'h333;
    end else begin
      w_pix = 12'hFFF;
    end
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      r_h_cnt     <= 10'd0;
      r_v_cnt     <= 10'd0;
      r_fresh     <= 1'b0;
      r_vis_d1    <= 1'b0;
      r_hs_d1     <= 1'b1;
      r_vs_d1     <= 1'b1;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_rdn       <= 1'b1;
      r_rgb       <= 12'h000;
      r_collision <= 1'b0;
    end else begin
      r_h_cnt  <= w_h_next;
      r_v_cnt  <= w_v_next;
      // Computed from the next count so fresh lines up with v_cnt without lag.
      r_fresh  <= (w_v_next >= L_V_VIS);
      r_vis_d1 <= w_vis;
      r_hs_d1  <= w_hs0;
      r_vs_d1  <= w_vs0;
      // px arriving now belongs to the address of the previous cycle, as does r_vis_d1.
      r_hs     <= r_hs_d1;
      r_vs     <= r_vs_d1;
      r_rdn    <= ~r_vis_d1;
      r_rgb    <= r_vis_d1 ? w_pix : 12'h000;
      if (r_vis_d1 && px_dino && px_cactus) begin
        r_collision <= 1'b1;
      end else if (clr_collision) begin
        r_collision <= 1'b0;
      end
    end
  end

  assign col_addr  = r_h_cnt;
  // 511 never matches a sprite row window, which blanks the layers during vblank.
  assign row_addr  = (r_v_cnt < L_V_VIS) ? r_v_cnt[8:0] : 9'd511;
  assign fresh     = r_fresh;
  assign hs        = r_hs;
  assign vs        = r_vs;
  assign rdn       = r_rdn;
  assign rgb       = r_rgb;
  assign collision = r_collision;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Self-checking bench for vga_scan_compositor on a shrunken raster: per-cycle scoreboard,
// table-driven priority vectors, and hand sequences for collision, blanking and reset.
module tb_vga_scan_compositor;

  localparam int HV = 40, HF = 4, HS = 8, HB = 4;
  localparam int VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clkdiv = 1'b0;
  logic        RESET = 1'b1;
  logic        px_dino = 1'b0;
  logic        px_cactus = 1'b0;
  logic        px_ground = 1'b0;
  logic        clr_collision = 1'b0;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh, hs, vs, rdn, collision;
  logic [11:0] rgb;

  vga_scan_compositor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clkdiv(clkdiv), .RESET(RESET),
    .px_dino(px_dino), .px_cactus(px_cactus), .px_ground(px_ground),
    .clr_collision(clr_collision),
    .row_addr(row_addr), .col_addr(col_addr), .fresh(fresh),
    .hs(hs), .vs(vs), .rdn(rdn), .rgb(rgb), .collision(collision)
  );

  always #5 clkdiv = ~clkdiv;

  typedef struct {
    int          h;
    int          v;
    bit          d;
    bit          c;
    bit          g;
    logic [11:0] rgb;
    bit          rdn;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        rdn;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_h, m_v, cyc;
  bit   m_coll, pend_coll;

  logic       p_hs, p_vs, p_rdn, p_fresh;
  logic [8:0] p_row;
  int         hs_len, vs_len, rdn_len, hs_last, vs_last;
  bit         hs_seen, vs_seen, rdn_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc %0d (h=%0d v=%0d): got %0h expected %0h", name, cyc, m_h, m_v,
               act, exp);
    end
  endtask

  function automatic logic [11:0] prio(input bit d, input bit c, input bit g);
    if (d) return 12'h555;
    if (c) return 12'h070;
    if (g) return 12'h333;
    return 12'hFFF;
  endfunction

  task automatic reset_model();
    exp_t e;
    m_h = 0; m_v = 0;
    m_coll = 1'b0; pend_coll = 1'b0;
    sb.delete();
    e.rgb = 12'h000; e.rdn = 1'b1; e.hs = 1'b1; e.vs = 1'b1;
    sb.push_back(e);
    p_hs = 1'b1; p_vs = 1'b1; p_rdn = 1'b1; p_fresh = 1'b0; p_row = 9'd0;
    hs_len = 0; vs_len = 0; rdn_len = 0;
    hs_seen = 1'b0; vs_seen = 1'b0; rdn_seen = 1'b0;
  endtask

  task automatic measure();
    if (p_hs && !hs) begin
      chk("hs_fall_col", col_addr, HV + HF + 2);
      if (hs_seen) chk("hs_period", cyc - hs_last, HT);
      hs_seen = 1'b1; hs_last = cyc; hs_len = 0;
    end
    if (!hs) hs_len++;
    if (!p_hs && hs && hs_seen) chk("hs_width", hs_len, HS);

    if (p_vs && !vs) begin
      chk("vs_fall_col", col_addr, 2);
      chk("vs_fall_row", row_addr, 511);
      if (vs_seen) chk("vs_period", cyc - vs_last, HT * VT);
      vs_seen = 1'b1; vs_last = cyc; vs_len = 0;
    end
    if (!vs) vs_len++;
    if (!p_vs && vs && vs_seen) chk("vs_width", vs_len, VS * HT);

    if (p_rdn && !rdn) begin
      rdn_seen = 1'b1; rdn_len = 0;
    end
    if (!rdn) rdn_len++;
    if (!p_rdn && rdn && rdn_seen) chk("rdn_width", rdn_len, HV);

    if (p_fresh && !fresh) begin
      chk("fresh_fall_row", row_addr, 0);
      chk("fresh_fall_prev_row", p_row, 511);
    end
    if (!p_fresh && fresh) chk("fresh_rise_prev_row", p_row, VV - 1);

    p_hs = hs; p_vs = vs; p_rdn = rdn; p_fresh = fresh; p_row = row_addr;
  endtask

  // One clock: check the new cycle's outputs, then drive px for the previous address.
  task automatic step(input bit d, input bit c, input bit g, input bit clr, input bit use_exp,
                      input logic [11:0] xrgb, input bit xrdn);
    exp_t e;
    int   ph, pv;
    bit   vis;
    @(posedge clkdiv);
    #1;
    cyc++;
    ph = m_h; pv = m_v;
    m_coll = pend_coll;
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty at cyc %0d: got 0 entries expected 1", cyc);
    end else begin
      e = sb.pop_front();
      chk("rgb", rgb, e.rgb);
      chk("rdn", rdn, e.rdn);
      chk("hs", hs, e.hs);
      chk("vs", vs, e.vs);
    end
    chk("col_addr", col_addr, m_h);
    chk("row_addr", row_addr, (m_v < VV) ? m_v : 511);
    chk("fresh", fresh, m_v >= VV);
    chk("collision", collision, m_coll);
    measure();

    px_dino = d; px_cactus = c; px_ground = g; clr_collision = clr;
    vis = (ph < HV) && (pv < VV);
    e.rgb = use_exp ? xrgb : (vis ? prio(d, c, g) : 12'h000);
    e.rdn = use_exp ? xrdn : !vis;
    e.hs  = !((ph >= HV + HF) && (ph < HV + HF + HS));
    e.vs  = !((pv >= VV + VF) && (pv < VV + VF + VS));
    sb.push_back(e);
    pend_coll = (vis && d && c) ? 1'b1 : (clr ? 1'b0 : m_coll);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(m_h == h && m_v == v) && n < 2 * HT * VT) begin
      idle();
      n++;
    end
    if (!(m_h == h && m_v == v)) begin
      checks++; failures++;
      $display("FAIL run_to timeout: got h=%0d v=%0d expected h=%0d v=%0d", m_h, m_v, h, v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_rdn"}, rdn, 1);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_fresh"}, fresh, 0);
    chk({tag, "_collision"}, collision, 0);
    chk({tag, "_col"}, col_addr, 0);
    chk({tag, "_row"}, row_addr, 0);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{h: HV - 1, v: 5,      d: 0, c: 0, g: 1, rgb: 12'h333, rdn: 0};
    tbl[1]  = '{h: HV,     v: 5,      d: 1, c: 0, g: 0, rgb: 12'h000, rdn: 1};
    tbl[2]  = '{h: 10,     v: 25,     d: 1, c: 1, g: 0, rgb: 12'h555, rdn: 0};
    tbl[3]  = '{h: 11,     v: 25,     d: 0, c: 1, g: 0, rgb: 12'h070, rdn: 0};
    tbl[4]  = '{h: 12,     v: 25,     d: 0, c: 0, g: 1, rgb: 12'h333, rdn: 0};
    tbl[5]  = '{h: 13,     v: 25,     d: 0, c: 0, g: 0, rgb: 12'hFFF, rdn: 0};
    tbl[6]  = '{h: 14,     v: 25,     d: 1, c: 0, g: 1, rgb: 12'h555, rdn: 0};
    tbl[7]  = '{h: 15,     v: 25,     d: 0, c: 1, g: 1, rgb: 12'h070, rdn: 0};
    tbl[8]  = '{h: HV + 5, v: 25,     d: 1, c: 0, g: 0, rgb: 12'h000, rdn: 1};
    tbl[9]  = '{h: 0,      v: VV - 1, d: 1, c: 0, g: 0, rgb: 12'h555, rdn: 0};
    tbl[10] = '{h: 0,      v: VV,     d: 0, c: 0, g: 1, rgb: 12'h000, rdn: 1};
    tbl[11] = '{h: 20,     v: VV + 3, d: 1, c: 1, g: 1, rgb: 12'h000, rdn: 1};

    cyc = 0;
    #12;
    chk_reset_vals("por");
    @(negedge clkdiv);
    RESET = 1'b0;
    reset_model();

    // Overlap outside the visible area must not latch.
    run_to(HV, 5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    idle();
    chk("blank_ovl_h", collision, 0);
    run_to(10, VV + 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    idle();
    chk("blank_ovl_v", collision, 0);

    for (int i = 0; i < 12; i++) begin
      run_to(tbl[i].h, tbl[i].v);
      step(tbl[i].d, tbl[i].c, tbl[i].g, 1'b0, 1'b1, tbl[i].rgb, tbl[i].rdn);
    end
    idle();
    idle();
    chk("coll_after_table", collision, 1);

    run_to(0, 0);
    run_to(3, 1);
    chk("coll_hold_wrap", collision, 1);

    run_to(5, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    idle();
    chk("coll_set_beats_clr", collision, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    idle();
    chk("coll_clr", collision, 0);
    run_to(12, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    idle();
    chk("coll_reset_prep", collision, 1);

    // Asynchronous reset in the middle of a visible line.
    run_to(30, 20);
    RESET = 1'b1;
    px_dino = 1'b0; px_cactus = 1'b0; px_ground = 1'b0; clr_collision = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clkdiv);
    RESET = 1'b0;
    #1;
    chk("post_rst_col0", col_addr, 0);
    chk("post_rst_row0", row_addr, 0);
    reset_model();
    idle();
    chk("post_rst_col1", col_addr, 1);
    chk("post_rst_row1", row_addr, 0);

    repeat (2 * HT * VT + 4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
